multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_if.sv | 31 +++
 rtl/multicycle_controller.sv | 132 +++++++++++++
 tb/tb_multicycle_controller.sv | 129 ++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control bus between the multicycle FSM and its datapath/memory.
interface multicycle_controller_if;
    logic [6:0]  Op;
    logic        Zero;
    logic        mem_ready;
    logic        mem_req;
    logic        AdrSrc;
    logic        IRWrite;
    logic        PCWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp;
    logic [2:0]  ImmSrc;
    logic [3:0]  state;
    logic        retire;
    logic        illegal;
    logic [31:0] instret;
    modport master (
        input  Op, Zero, mem_ready,
        output mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, ImmSrc, state, retire, illegal, instret
    );
    modport slave (
        output Op, Zero, mem_ready,
        input  mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, ImmSrc, state, retire, illegal, instret
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: RISC-V style multicycle control FSM with memory wait states,
// illegal-opcode trap and retired-instruction counter.
module multicycle_controller (
    input logic clk,
    input logic rst,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
        MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
        ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10, TRAP = 4'd11
    } state_t;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    state_t      cur, nxt;
    logic [31:0] instret_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= FETCH;
            instret_q <= '0;
        end else begin
            cur       <= nxt;
            instret_q <= instret_q + {31'd0, bus.retire};
        end
    end
    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:    nxt = bus.mem_ready ? DECODE : FETCH;
            DECODE:   nxt = (bus.Op == OP_LW || bus.Op == OP_SW) ? MEMADR :
                            (bus.Op == OP_R)   ? EXECR :
                            (bus.Op == OP_I)   ? EXECI :
                            (bus.Op == OP_B)   ? BEQ :
                            (bus.Op == OP_JAL) ? JAL : TRAP;
            MEMADR:   nxt = (bus.Op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  nxt = bus.mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: nxt = bus.mem_ready ? FETCH : MEMWRITE;
            EXECR, EXECI, JAL: nxt = ALUWB;
            TRAP:     nxt = TRAP;
            default:  nxt = FETCH;
        endcase
    end
    // Under reset the selects show their FETCH values; strobes are masked afterwards.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.PCWrite   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.ALUOp     = 2'b00;
        bus.retire    = 1'b0;
        bus.illegal   = 1'b0;
        case (rst ? FETCH : cur)
            FETCH: begin
                bus.mem_req   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = bus.mem_ready;
                bus.PCWrite   = bus.mem_ready;
            end
            DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                bus.mem_req = 1'b1;
                bus.AdrSrc  = 1'b1;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
                bus.retire    = 1'b1;
            end
            MEMWRITE: begin
                bus.mem_req  = 1'b1;
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = bus.mem_ready;
                bus.retire   = bus.mem_ready;
            end
            EXECR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUOp   = 2'b10;
            end
            EXECI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = 2'b10;
            end
            ALUWB: begin
                bus.RegWrite = 1'b1;
                bus.retire   = 1'b1;
            end
            BEQ: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUOp   = 2'b01;
                bus.PCWrite = bus.Zero;
                bus.retire  = 1'b1;
            end
            JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.PCWrite = 1'b1;
            end
            TRAP:    bus.illegal = 1'b1;
            default: ;
        endcase
        if (rst) begin
            bus.mem_req = 1'b0;
            bus.IRWrite = 1'b0;
            bus.PCWrite = 1'b0;
        end
    end
    assign bus.ImmSrc  = (bus.Op == OP_LW)  ? 3'b000 :
                         (bus.Op == OP_SW)  ? 3'b001 :
                         (bus.Op == OP_B)   ? 3'b010 :
                         (bus.Op == OP_JAL) ? 3'b011 :
                         (bus.Op == OP_I)   ? 3'b100 : 3'b101;
    assign bus.state   = cur;
    assign bus.instret = instret_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle expectations queued by the stimulus and
// checked by an independent negedge monitor.
module tb_multicycle_controller;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IA = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111, BAD = 7'b1110011;
    // {ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
    localparam logic [7:0] S_F = 8'b10_00_10_00, S_D = 8'b00_01_01_00, S_MA = 8'b00_10_01_00;
    localparam logic [7:0] S_WB = 8'b01_00_00_00, S_ER = 8'b00_10_00_10, S_EI = 8'b00_10_01_10;
    localparam logic [7:0] S_B = 8'b00_10_00_01, S_J = 8'b00_01_10_00, S_0 = 8'b0;
    // {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite}
    localparam logic [5:0] K_F1 = 6'b101100, K_F0 = 6'b100000, K_MEM = 6'b110000;
    localparam logic [5:0] K_ST = 6'b110010, K_RW = 6'b000001, K_PC = 6'b000100, K_0 = 6'b0;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] n = '0;
    logic [54:0] q[$];
    int          compared = 0;
    int          mismatched = 0;
    multicycle_controller_if bus();
    multicycle_controller dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [2:0] imm_exp(input logic [6:0] op);
        case (op)
            LW:      return 3'b000;
            SW:      return 3'b001;
            BR:      return 3'b010;
            JL:      return 3'b011;
            IA:      return 3'b100;
            default: return 3'b101;
        endcase
    endfunction
    task automatic step(input logic r, input logic [6:0] op, input logic z, input logic mr,
                        input logic [3:0] st, input logic [5:0] strb, input logic [7:0] sel,
                        input logic ret, input logic ill);
        rst = r;
        bus.Op = op;
        bus.Zero = z;
        bus.mem_ready = mr;
        q.push_back({st, strb, sel, imm_exp(op), ret, ill, n});
        n = r ? 32'd0 : n + {31'd0, ret};
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        logic [54:0] act, e;
        if (q.size() != 0) begin
            e = q.pop_front();
            act = {bus.state, bus.mem_req, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.MemWrite,
                   bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc,
                   bus.retire, bus.illegal, bus.instret};
            compared++;
            if (act !== e) begin
                mismatched++;
                $display("FAIL vec%0d: got %h expected %h (state %0d vs %0d)",
                         compared, act, e, act[54:51], e[54:51]);
            end
        end
    end
    initial begin
        bus.Op = RT;
        bus.Zero = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step(1, RT, 0, 1, 4'd0, K_0, S_F, 0, 0);
        // R-type
        step(0, RT, 0, 1, 4'd0, K_F1, S_F, 0, 0);
        step(0, RT, 0, 1, 4'd1, K_0, S_D, 0, 0);
        step(0, LW, 0, 1, 4'd6, K_0, S_ER, 0, 0);
        step(0, LW, 0, 1, 4'd8, K_RW, S_0, 1, 0);
        // LW with two wait cycles in MEMREAD; Op changes there are ignored
        step(0, LW, 0, 1, 4'd0, K_F1, S_F, 0, 0);
        step(0, LW, 0, 1, 4'd1, K_0, S_D, 0, 0);
        step(0, LW, 0, 1, 4'd2, K_0, S_MA, 0, 0);
        step(0, SW, 0, 0, 4'd3, K_MEM, S_0, 0, 0);
        step(0, RT, 0, 0, 4'd3, K_MEM, S_0, 0, 0);
        step(0, LW, 0, 1, 4'd3, K_MEM, S_0, 0, 0);
        step(0, SW, 0, 1, 4'd4, K_RW, S_WB, 1, 0);
        // SW with a fetch wait and a store wait
        step(0, SW, 0, 0, 4'd0, K_F0, S_F, 0, 0);
        step(0, SW, 0, 1, 4'd0, K_F1, S_F, 0, 0);
        step(0, SW, 0, 1, 4'd1, K_0, S_D, 0, 0);
        step(0, SW, 0, 1, 4'd2, K_0, S_MA, 0, 0);
        step(0, SW, 0, 0, 4'd5, K_MEM, S_0, 0, 0);
        step(0, SW, 0, 1, 4'd5, K_ST, S_0, 1, 0);
        // I-ALU
        step(0, IA, 0, 1, 4'd0, K_F1, S_F, 0, 0);
        step(0, IA, 0, 1, 4'd1, K_0, S_D, 0, 0);
        step(0, IA, 0, 1, 4'd7, K_0, S_EI, 0, 0);
        step(0, IA, 0, 1, 4'd8, K_RW, S_0, 1, 0);
        // BEQ taken then not taken
        step(0, BR, 1, 1, 4'd0, K_F1, S_F, 0, 0);
        step(0, BR, 1, 1, 4'd1, K_0, S_D, 0, 0);
        step(0, BR, 1, 1, 4'd9, K_PC, S_B, 1, 0);
        step(0, BR, 0, 1, 4'd0, K_F1, S_F, 0, 0);
        step(0, BR, 0, 1, 4'd1, K_0, S_D, 0, 0);
        step(0, BR, 0, 1, 4'd9, K_0, S_B, 1, 0);
        // Illegal opcode traps until reset
        step(0, BAD, 0, 1, 4'd0, K_F1, S_F, 0, 0);
        step(0, BAD, 0, 1, 4'd1, K_0, S_D, 0, 0);
        for (int i = 0; i < 12; i++)
            step(0, (i % 3 == 0) ? LW : BAD, i[0], i[1], 4'd11, K_0, S_0, 0, 1);
        step(1, BAD, 0, 1, 4'd11, K_0, S_F, 0, 0);
        // Reset while a store is stalled
        step(0, SW, 0, 1, 4'd0, K_F1, S_F, 0, 0);
        step(0, SW, 0, 1, 4'd1, K_0, S_D, 0, 0);
        step(0, SW, 0, 1, 4'd2, K_0, S_MA, 0, 0);
        step(0, SW, 0, 0, 4'd5, K_MEM, S_0, 0, 0);
        step(1, SW, 0, 0, 4'd5, K_0, S_F, 0, 0);
        step(0, JL, 0, 0, 4'd0, K_F0, S_F, 0, 0);
        // JAL retiring with the counter at its maximum
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        n = 32'hFFFF_FFFF;
        step(0, JL, 0, 1, 4'd0, K_F1, S_F, 0, 0);
        step(0, JL, 0, 1, 4'd1, K_0, S_D, 0, 0);
        step(0, JL, 0, 1, 4'd10, K_PC, S_J, 0, 0);
        step(0, JL, 0, 1, 4'd8, K_RW, S_0, 1, 0);
        step(0, JL, 0, 0, 4'd0, K_F0, S_F, 0, 0);
        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
